jk_ff_bank: RTL



---
 rtl/jk_ff_pkg.sv | 17 +
 rtl/jk_ff_cell.sv | 93 +++++++++
 rtl/jk_ff_bank.sv | 59 +++++
 3 files changed

// File: rtl/jk_ff_pkg.sv
// Shared constants for the jk_ff_bank flip-flop bank.
//   mode_e   : per-edge update mode selector (JK, SR, D, T)
//   SR_*     : next-state policy for a bit that sees S=R=1 in SR mode
package jk_ff_pkg;

   typedef enum logic [1:0] {
      MODE_JK = 2'b00,
      MODE_SR = 2'b01,
      MODE_D  = 2'b10,
      MODE_T  = 2'b11
   } mode_e;

   localparam int SR_HOLD = 0;
   localparam int SR_SET  = 1;
   localparam int SR_RST  = 2;

endpackage

// File: rtl/jk_ff_cell.sv
// Single bit of the flip-flop bank: state bit, change pulse and sticky
// SR-illegal flag.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en_i       in   mode-driven update enable
//   mode_i     in   update mode (JK/SR/D/T)
//   j_i, k_i   in   J/S/D/T and K/R inputs
//   ld_i       in   parallel-load strobe
//   ld_val_i   in   value loaded when ld_i=1
//   clr_err_i  in   clears the sticky error flag
//   q_o        out  registered state
//   changed_o  out  one-cycle pulse: q changed on the previous edge
//   err_sr_o   out  sticky flag: S=R=1 seen in SR mode
module jk_ff_cell
   import jk_ff_pkg::*;
#(
   parameter logic RESET_BIT         = 1'b0,
   parameter int   SR_ILLEGAL_POLICY = SR_HOLD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] mode_i,
   input  logic       j_i,
   input  logic       k_i,
   input  logic       ld_i,
   input  logic       ld_val_i,
   input  logic       clr_err_i,
   output logic       q_o,
   output logic       changed_o,
   output logic       err_sr_o
);

   logic q_q, q_d;
   logic changed_q, changed_d;
   logic err_q, err_d;

   always_comb begin
      q_d   = q_q;
      err_d = clr_err_i ? 1'b0 : err_q;
      if (ld_i) begin
         q_d = ld_val_i;
      end else if (en_i) begin
         case (mode_e'(mode_i))
            MODE_JK: begin
               case ({j_i, k_i})
                  2'b01:   q_d = 1'b0;
                  2'b10:   q_d = 1'b1;
                  2'b11:   q_d = ~q_q;
                  default: q_d = q_q;
               endcase
            end
            MODE_SR: begin
               case ({j_i, k_i})
                  2'b01: q_d = 1'b0;
                  2'b10: q_d = 1'b1;
                  2'b11: begin
                     // a fresh illegal condition beats a same-edge clear
                     err_d = 1'b1;
                     case (SR_ILLEGAL_POLICY)
                        SR_SET:  q_d = 1'b1;
                        SR_RST:  q_d = 1'b0;
                        default: q_d = q_q;
                     endcase
                  end
                  default: q_d = q_q;
               endcase
            end
            MODE_D:  q_d = j_i;
            MODE_T:  q_d = q_q ^ j_i;
            default: q_d = q_q;
         endcase
      end
      changed_d = q_d ^ q_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q       <= RESET_BIT;
         changed_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         q_q       <= q_d;
         changed_q <= changed_d;
         err_q     <= err_d;
      end
   end

   assign q_o       = q_q;
   assign changed_o = changed_q;
   assign err_sr_o  = err_q;

endmodule

// File: rtl/jk_ff_bank.sv
// WIDTH-bit bank of mode-selectable flip-flops (JK, SR, D, T) with shared
// clock, synchronous reset, enable, parallel load and sticky SR-illegal flags.
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (q=RESET_VAL)
//   en       in   mode-driven update enable
//   mode     in   00=JK 01=SR 10=D 11=T
//   j, k     in   per-bit J/S/D/T and K/R inputs
//   ld       in   parallel-load strobe (beats en)
//   ld_val   in   load value
//   clr_err  in   clears err_sr
//   q        out  registered state
//   qb       out  ~q
//   changed  out  per-bit change pulse from the previous edge
//   err_sr   out  per-bit sticky S=R=1 flag
module jk_ff_bank
   import jk_ff_pkg::*;
#(
   parameter int               WIDTH             = 8,
   parameter logic [WIDTH-1:0] RESET_VAL         = {WIDTH{1'b0}},
   parameter int               SR_ILLEGAL_POLICY = SR_HOLD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic [WIDTH-1:0] changed,
   output logic [WIDTH-1:0] err_sr
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_ff_cell #(
         .RESET_BIT         (RESET_VAL[i]),
         .SR_ILLEGAL_POLICY (SR_ILLEGAL_POLICY)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .en_i      (en),
         .mode_i    (mode),
         .j_i       (j[i]),
         .k_i       (k[i]),
         .ld_i      (ld),
         .ld_val_i  (ld_val[i]),
         .clr_err_i (clr_err),
         .q_o       (q[i]),
         .changed_o (changed[i]),
         .err_sr_o  (err_sr[i])
      );
   end

   assign qb = ~q;

endmodule
